// File: rtl/data_out_driver_if.sv
// Write-request and bus-side signals of the data-out driver.
// The master (core side) drives the request channel and tick; the slave (driver) owns the bus.
interface data_out_driver_if;
  logic        clk_en;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        phi2;
  logic [15:0] address;
  logic        rw;
  logic [7:0]  data;
  logic        data_oe;
  logic        done;

  modport master (
    output clk_en, wr_valid, wr_addr, wr_data,
    input  wr_ready, phi2, address, rw, data, data_oe, done
  );

  modport slave (
    input  clk_en, wr_valid, wr_addr, wr_data,
    output wr_ready, phi2, address, rw, data, data_oe, done
  );
endinterface

// File: rtl/data_out_driver.sv
// Two-phase bus write driver: buffers core writes in a 2-entry FIFO and plays each one out
// as SETUP (phi1) / DRIVE (phi2) with an optional HOLD phase keeping data on the bus.
module data_out_driver #(
  parameter int HOLD_EN    = 1,
  parameter int FIFO_DEPTH = 2
) (
  input logic              i_clk,
  input logic              i_reset_n,
  data_out_driver_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, DRIVE, HOLD} state_t;

  localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

  state_t      state;
  logic        phase;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;
  logic        rw;
  logic        data_oe;
  logic        done;

  logic [23:0] fifo_mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;
  logic [23:0] head;

  assign bus.wr_ready = (count < DEPTH_C);
  assign push         = bus.wr_valid && bus.wr_ready;
  assign head         = fifo_mem[rd_ptr];

  // A pop always lands the new entry in SETUP, which starts on a phi1 phase.
  always_comb begin
    pop = 1'b0;
    if (bus.clk_en && (count != 2'd0)) begin
      if ((state == IDLE) && phase)
        pop = 1'b1;
      else if ((state == DRIVE) && (HOLD_EN == 0))
        pop = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {bus.wr_addr, bus.wr_data};
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      phase    <= 1'b0;
      bus_addr <= 16'h0000;
      bus_data <= 8'h00;
      rw       <= 1'b1;
      data_oe  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.clk_en) begin
        phase <= ~phase;
        case (state)
          IDLE: begin
            if (pop) begin
              state                <= SETUP;
              {bus_addr, bus_data} <= head;
              rw                   <= 1'b0;
            end
          end
          SETUP: begin
            state   <= DRIVE;
            data_oe <= 1'b1;
          end
          DRIVE: begin
            done <= 1'b1;
            if (HOLD_EN != 0) begin
              state <= HOLD;
            end else if (pop) begin
              state                <= SETUP;
              {bus_addr, bus_data} <= head;
              data_oe              <= 1'b0;
            end else begin
              state   <= IDLE;
              rw      <= 1'b1;
              data_oe <= 1'b0;
            end
          end
          HOLD: begin
            state   <= IDLE;
            rw      <= 1'b1;
            data_oe <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.phi2    = phase;
  assign bus.address = bus_addr;
  assign bus.data    = bus_data;
  assign bus.rw      = rw;
  assign bus.data_oe = data_oe;
  assign bus.done    = done;
endmodule

// File: tb/tb_data_out_driver.sv
// Bench for data_out_driver: vector table for a single write, directed corner sequences,
// and a randomized run scored against a transaction-level model on HOLD_EN=1 and HOLD_EN=0 instances.
module tb_data_out_driver;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_out_driver_if bus_a ();
  data_out_driver_if bus_b ();

  data_out_driver #(.HOLD_EN(1), .FIFO_DEPTH(2)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus_a.slave));
  data_out_driver #(.HOLD_EN(0), .FIFO_DEPTH(2)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus_b.slave));

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        en;
    logic        vld;
    logic [15:0] addr;
    logic [7:0]  dat;
    logic [28:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Output snapshot: {ready, phi2, rw, oe, done, address, data}
  function automatic logic [28:0] mk(input logic r, input logic p, input logic w, input logic o,
                                     input logic d, input logic [15:0] a, input logic [7:0] dt);
    return {r, p, w, o, d, a, dt};
  endfunction

  function automatic logic [28:0] snap_a();
    return {bus_a.wr_ready, bus_a.phi2, bus_a.rw, bus_a.data_oe, bus_a.done, bus_a.address, bus_a.data};
  endfunction

  function automatic logic [28:0] snap_b();
    return {bus_b.wr_ready, bus_b.phi2, bus_b.rw, bus_b.data_oe, bus_b.done, bus_b.address, bus_b.data};
  endfunction

  task automatic set_a(input logic en, input logic vld, input logic [15:0] a, input logic [7:0] d);
    bus_a.clk_en = en; bus_a.wr_valid = vld; bus_a.wr_addr = a; bus_a.wr_data = d;
  endtask

  task automatic set_b(input logic en, input logic vld, input logic [15:0] a, input logic [7:0] d);
    bus_b.clk_en = en; bus_b.wr_valid = vld; bus_b.wr_addr = a; bus_b.wr_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tick A every clock until it sits in DRIVE (data enabled during phi2).
  task automatic tick_a_to_drive(input string name);
    logic found;
    found = 1'b0;
    set_a(1'b1, 1'b0, 16'h0, 8'h0);
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus_a.data_oe && bus_a.phi2) found = 1'b1;
    end
    check(name, found, 1'b1);
  endtask

  vec_t        vecs [11];
  logic [23:0] got [$];
  logic [23:0] q_a [$];
  logic [23:0] q_b [$];
  logic [28:0] s0;

  initial begin
    int done_cnt;
    int done_idx [$];
    logic [23:0] drive_word [$];
    logic [28:0] done_snap;
    logic [28:0] prev_b;
    logic phase_m;

    vecs[0]  = '{1'b0, 1'b1, 16'h2000, 8'h5A, mk(1, 0, 1, 0, 0, 16'h0000, 8'h00)};
    vecs[1]  = '{1'b1, 1'b0, 16'h0000, 8'h00, mk(1, 1, 1, 0, 0, 16'h0000, 8'h00)};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 8'h00, mk(1, 1, 1, 0, 0, 16'h0000, 8'h00)};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 8'h00, mk(1, 0, 0, 0, 0, 16'h2000, 8'h5A)};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 8'h00, mk(1, 0, 0, 0, 0, 16'h2000, 8'h5A)};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 8'h00, mk(1, 1, 0, 1, 0, 16'h2000, 8'h5A)};
    vecs[6]  = '{1'b0, 1'b0, 16'h0000, 8'h00, mk(1, 1, 0, 1, 0, 16'h2000, 8'h5A)};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 8'h00, mk(1, 0, 0, 1, 1, 16'h2000, 8'h5A)};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 8'h00, mk(1, 0, 0, 1, 0, 16'h2000, 8'h5A)};
    vecs[9]  = '{1'b1, 1'b0, 16'h0000, 8'h00, mk(1, 1, 1, 0, 0, 16'h2000, 8'h5A)};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 8'h00, mk(1, 1, 1, 0, 0, 16'h2000, 8'h5A)};

    rst_n = 1'b0;
    set_a(1'b1, 1'b1, 16'hFFFF, 8'hFF);
    set_b(1'b0, 1'b0, 16'h0, 8'h0);
    step(); step();
    check("reset_a", snap_a(), mk(1, 0, 1, 0, 0, 16'h0000, 8'h00));
    check("reset_b", snap_b(), mk(1, 0, 1, 0, 0, 16'h0000, 8'h00));
    rst_n = 1'b1;
    set_a(1'b0, 1'b0, 16'h0, 8'h0);

    // Single write, tick every second clock
    for (int i = 0; i < 11; i++) begin
      set_a(vecs[i].en, vecs[i].vld, vecs[i].addr, vecs[i].dat);
      step();
      check($sformatf("vec%0d", i), snap_a(), vecs[i].exp);
    end

    // Three back-to-back pushes with no tick: third is refused
    set_a(1'b0, 1'b1, 16'h1111, 8'h11); step();
    check("ready_after_1", bus_a.wr_ready, 1'b1);
    set_a(1'b0, 1'b1, 16'h2222, 8'h22); step();
    check("ready_after_2", bus_a.wr_ready, 1'b0);
    set_a(1'b0, 1'b1, 16'h3333, 8'h33); step();
    check("ready_after_3", bus_a.wr_ready, 1'b0);
    set_a(1'b1, 1'b0, 16'h0, 8'h0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus_a.done) got.push_back({bus_a.address, bus_a.data});
    end
    check("full_done_count", got.size(), 2);
    if (got.size() == 2) begin
      check("full_first", got[0], 24'h1111_11);
      check("full_second", got[1], 24'h2222_22);
    end

    // Tick stall in DRIVE: everything frozen, done only on the releasing tick
    set_a(1'b0, 1'b1, 16'h4444, 8'h44); step();
    tick_a_to_drive("stall_reach_drive");
    set_a(1'b0, 1'b0, 16'h0, 8'h0);
    s0 = snap_a();
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("stall_hold%0d", i), snap_a(), mk(1, 1, 0, 1, 0, 16'h4444, 8'h44));
    end
    set_a(1'b1, 1'b0, 16'h0, 8'h0); step();
    check("stall_release_done", bus_a.done, 1'b1);
    set_a(1'b0, 1'b0, 16'h0, 8'h0); step();
    check("stall_done_one_clk", bus_a.done, 1'b0);

    // Reset in DRIVE with an entry still queued
    set_a(1'b0, 1'b1, 16'h5555, 8'h55); step();
    set_a(1'b0, 1'b1, 16'h6666, 8'h66); step();
    tick_a_to_drive("rst_reach_drive");
    rst_n = 1'b0;
    set_a(1'b1, 1'b0, 16'h0, 8'h0); step();
    check("rst_in_drive", snap_a(), mk(1, 0, 1, 0, 0, 16'h0000, 8'h00));
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus_a.done) done_cnt++;
    end
    check("rst_fifo_empty", done_cnt, 0);

    // HOLD_EN=0: DRIVE(A) straight into SETUP(B), one tick every clock
    set_b(1'b0, 1'b1, 16'hA001, 8'hA1); step();
    set_b(1'b0, 1'b1, 16'hB002, 8'hB2); step();
    set_b(1'b1, 1'b0, 16'h0, 8'h0);
    prev_b = snap_b();
    done_snap = '0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus_b.done) begin
        done_idx.push_back(i);
        drive_word.push_back(prev_b[23:0]);
        if (done_idx.size() == 1) done_snap = snap_b();
      end
      prev_b = snap_b();
    end
    check("b2b_done_count", done_idx.size(), 2);
    if (done_idx.size() == 2) begin
      check("b2b_spacing", done_idx[1] - done_idx[0], 2);
      check("b2b_word_a", drive_word[0], 24'hA001_A1);
      check("b2b_word_b", drive_word[1], 24'hB002_B2);
      check("b2b_setup_b", done_snap, mk(1, 0, 0, 0, 1, 16'hB002, 8'hB2));
    end

    // Randomized traffic against a transaction scoreboard
    rst_n = 1'b0;
    set_a(1'b0, 1'b0, 16'h0, 8'h0);
    set_b(1'b0, 1'b0, 16'h0, 8'h0);
    step();
    rst_n = 1'b1;
    phase_m = 1'b0;
    for (int i = 0; i < 640; i++) begin
      logic en, acc_a, acc_b, oe_a, oe_b;
      logic [15:0] ad_a, ad_b;
      logic [7:0] dt_a, dt_b;
      logic [23:0] pre_a, pre_b;
      en = (i < 600) ? ($urandom_range(0, 2) != 0) : 1'b1;
      ad_a = 16'($urandom); dt_a = 8'($urandom);
      ad_b = 16'($urandom); dt_b = 8'($urandom);
      set_a(en, (i < 600) && ($urandom_range(0, 1) == 1), ad_a, dt_a);
      set_b(en, (i < 600) && ($urandom_range(0, 1) == 1), ad_b, dt_b);
      #1;
      acc_a = bus_a.wr_valid && bus_a.wr_ready;
      acc_b = bus_b.wr_valid && bus_b.wr_ready;
      pre_a = {bus_a.address, bus_a.data}; oe_a = bus_a.data_oe;
      pre_b = {bus_b.address, bus_b.data}; oe_b = bus_b.data_oe;
      step();
      if (acc_a) q_a.push_back({ad_a, dt_a});
      if (acc_b) q_b.push_back({ad_b, dt_b});
      phase_m = phase_m ^ en;
      check("rnd_phi2_a", bus_a.phi2, phase_m);
      check("rnd_phi2_b", bus_b.phi2, phase_m);
      if (!en) begin
        check("rnd_done_gated_a", bus_a.done, 1'b0);
        check("rnd_done_gated_b", bus_b.done, 1'b0);
      end
      if (bus_a.done) begin
        check("rnd_done_oe_a", oe_a, 1'b1);
        if (q_a.size() == 0) check("rnd_extra_done_a", q_a.size(), 1);
        else check("rnd_word_a", pre_a, q_a.pop_front());
      end
      if (bus_b.done) begin
        check("rnd_done_oe_b", oe_b, 1'b1);
        if (q_b.size() == 0) check("rnd_extra_done_b", q_b.size(), 1);
        else check("rnd_word_b", pre_b, q_b.pop_front());
      end
    end
    check("rnd_drain_a", q_a.size(), 0);
    check("rnd_drain_b", q_b.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
